// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, controller states and small op-decoding helpers.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Even encodings are the signed variants; bit 1 selects divide.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on a packed {upper, lower} accumulator.
module mult_div_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 quot_bit
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Multiply keeps the multiplier in the low half and shifts the product in from
    // the top; divide keeps the partial remainder on top with one guard bit.
    always_comb begin
        addend   = acc[0] ? operand : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        quot_bit = 1'b0;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            quot_bit = ~diff[WIDTH];
            acc_next = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO result registers.
// Works on operand magnitudes for WIDTH cycles, then fixes signs in one extra cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               step_quot;
    logic               a_neg, b_neg, zero_div;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] product;

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (step_acc),
        .quot_bit (step_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign a_neg    = op_is_signed(op) & a[WIDTH-1];
    assign b_neg    = op_is_signed(op) & b[WIDTH-1];
    assign zero_div = op_is_div(op) & (b == '0);
    assign mag_a    = a_neg ? -a : a;
    assign mag_b    = b_neg ? -b : b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !zero_div) state_d = RUN;
            RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A zero divisor is answered straight from IDLE and leaves HI/LO untouched.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        product    = neg_lo_q ? -acc_q : acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_div) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        opnd_d   = mag_b;
                        is_div_d = op_is_div(op);
                        cnt_d    = '0;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = op_is_div(op) ? a_neg : (a_neg ^ b_neg);
                    end
                end
            end
            RUN: begin
                acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_quot};
                cnt_d = cnt_q + CW'(1);
            end
            FIX: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit at WIDTH=32 and WIDTH=8,
// checked against an arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start8;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi [2];
    logic [31:0] exp_lo [2];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    // Reference: signed/unsigned integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] mh,
                                  output logic [31:0] ml, output bit dz);
        logic [63:0] m, ux, uy, p;
        longint vx, vy, q, r;
        m  = (64'd1 << w) - 64'd1;
        ux = {32'd0, x} & m;
        uy = {32'd0, y} & m;
        vx = longint'(ux);
        vy = longint'(uy);
        if (o[0] == 1'b0 && ux[w-1]) vx = vx - longint'(64'd1 << w);
        if (o[0] == 1'b0 && uy[w-1]) vy = vy - longint'(64'd1 << w);
        dz = 1'b0;
        mh = '0;
        ml = '0;
        if (o[1] == 1'b0) begin
            p  = 64'(vx * vy);
            mh = 32'((p >> w) & m);
            ml = 32'(p & m);
        end else if (vy == 0) begin
            dz = 1'b1;
        end else begin
            q  = vx / vy;
            r  = vx % vy;
            ml = 32'(64'(q) & m);
            mh = 32'(64'(r) & m);
        end
    endfunction

    function automatic logic cur_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction
    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction
    function automatic logic cur_dz(input bit w8);
        return w8 ? dz8 : dz32;
    endfunction
    function automatic logic [31:0] cur_hi(input bit w8);
        return w8 ? {24'd0, hi8} : hi32;
    endfunction
    function automatic logic [31:0] cur_lo(input bit w8);
        return w8 ? {24'd0, lo8} : lo32;
    endfunction

    task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input string name);
        int w, k, exp_lat;
        bit dz, got, busy_ok;
        logic [31:0] mh, ml;
        w = w8 ? 8 : 32;
        model(w, o, x, y, mh, ml, dz);
        if (!dz) begin
            exp_hi[w8] = mh;
            exp_lo[w8] = ml;
        end
        exp_lat = dz ? 1 : w + 2;
        @(negedge clk);
        op = o; a = x; b = y;
        if (w8) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        k = 1; got = 0; busy_ok = 1;
        while (k <= w + 4) begin
            if (cur_done(w8) === 1'b1) begin
                got = 1;
                break;
            end
            if (cur_busy(w8) !== !dz) busy_ok = 0;
            @(negedge clk);
            k++;
        end
        checks++;
        if (!got || k != exp_lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got=%0b cycles=%0d required=%0d", name, got, k, exp_lat);
        end
        checks++;
        if (!busy_ok || cur_busy(w8) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s busy window: busy_ok=%0b busy_at_done=%b", name, busy_ok, cur_busy(w8));
        end
        checks++;
        if (cur_dz(w8) !== dz) begin
            errors++;
            $display("[TB] FAIL %s div_zero: actual=%b required=%b", name, cur_dz(w8), dz);
        end
        checks++;
        if (cur_hi(w8) !== exp_hi[w8]) begin
            errors++;
            $display("[TB] FAIL %s hi: actual=%h required=%h", name, cur_hi(w8), exp_hi[w8]);
        end
        checks++;
        if (cur_lo(w8) !== exp_lo[w8]) begin
            errors++;
            $display("[TB] FAIL %s lo: actual=%h required=%h", name, cur_lo(w8), exp_lo[w8]);
        end
        @(negedge clk);
        checks++;
        if (cur_done(w8) !== 1'b0 || cur_dz(w8) !== 1'b0 || cur_busy(w8) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s after_done: done=%b div_zero=%b busy=%b required 0/0/0",
                     name, cur_done(w8), cur_dz(w8), cur_busy(w8));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start8 = 1'b0; op = OP_MULT; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || dz32 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b div_zero=%b required 0", busy32, done32, dz32);
        end
        checks++;
        if (hi32 !== 32'd0 || lo32 !== 32'd0 || hi8 !== 8'd0 || lo8 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: hi=%h lo=%h hi8=%h lo8=%h required 0", hi32, lo32, hi8, lo8);
        end
    endtask

    task automatic test_directed();
        run_op(0, OP_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
        run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(0, OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
        run_op(0, OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg7by2");
        run_op(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_minbym1");
        run_op(0, OP_DIVU,  32'd7,         32'd2,         "divu_7by2");
        run_op(0, OP_DIVU,  32'd5,         32'd0,         "divu_by_zero");
        run_op(0, OP_DIV,   32'h8000_0000, 32'd0,         "div_by_zero");
        run_op(1, OP_MULT,  32'h80,        32'h80,        "w8_mult_min");
        run_op(1, OP_DIV,   32'h80,        32'hFF,        "w8_div_minbym1");
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: x = 32'h8000_0000;
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(0, o, x, y, "rand32");
        end
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(1, o, x, y, "rand8");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h1, l1, h2, l2;
        bit dz;
        int k, extra;
        model(32, OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, h1, l1, dz);
        model(32, OP_DIV,   32'hF000_0001, 32'h0000_0123, h2, l2, dz);
        @(negedge clk);
        op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 1;
        while (done32 !== 1'b1 && k <= 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done32 !== 1'b1 || hi32 !== h1 || lo32 !== l1) begin
            errors++;
            $display("[TB] FAIL b2b_first: done=%b hi=%h lo=%h required 1 %h %h", done32, hi32, lo32, h1, l1);
        end
        op = OP_DIV; a = 32'hF000_0001; b = 32'h0000_0123; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; k = 1;
        while (done32 !== 1'b1 && k <= 40) begin
            if (k == 5) begin
                start = 1'b1; op = OP_MULT; a = 32'h0000_0777; b = 32'h0000_0003;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checks++;
        if (done32 !== 1'b1 || k != 34) begin
            errors++;
            $display("[TB] FAIL b2b_latency: done=%b cycles=%0d required 34", done32, k);
        end
        checks++;
        if (hi32 !== h2 || lo32 !== l2) begin
            errors++;
            $display("[TB] FAIL b2b_second: hi=%h lo=%h required %h %h", hi32, lo32, h2, l2);
        end
        exp_hi[0] = h2; exp_lo[0] = l2;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL b2b_ignored_start: extra_done=%0d required 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int extra;
        @(negedge clk);
        op = OP_MULT; a = $urandom; b = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: busy=%b done=%b hi=%h lo=%h required 0", busy32, done32, hi32, lo32);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1 || busy32 === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL midrun_discard: activity_cycles=%0d required 0", extra);
        end
        run_op(0, OP_MULTU, 32'd3, 32'd4, "multu_after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
